// File: rtl/hazard_sched_if.sv
// Decode-side scheduler bundle: decode instruction fields and branch
// resolution in, stall/flush/NOP controls and status out.
interface hazard_sched_if;
  logic        id_valid;
  logic [2:0]  id_rs;
  logic        id_rs_used;
  logic [2:0]  id_rt;
  logic        id_rt_used;
  logic [2:0]  id_rd;
  logic        id_regwrt;
  logic        id_halt;
  logic        ex_branch_taken;
  logic        nop_mech;
  logic        stall_pc;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regwrt,
           id_halt, ex_branch_taken,
    output nop_mech, stall_pc, stall_ifid, flush_ifid, halted, stall_cnt, state
  );

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regwrt,
           id_halt, ex_branch_taken,
    input  nop_mech, stall_pc, stall_ifid, flush_ifid, halted, stall_cnt, state
  );
endinterface

// File: rtl/hazard_sched.sv
// Decode-stage scheduler: shift-register scoreboard of in-flight writers,
// RAW hazard detection, branch flush sequencing and HALT drain.
// Control outputs are combinational from registered state so a stall takes
// effect in the same cycle the hazard is seen.
module hazard_sched #(
  parameter int DEPTH     = 3,
  parameter int BYPASS    = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  hazard_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Slots older than CMP_LAST are covered by the register-file write bypass.
  localparam int         CMP_LAST   = DEPTH - 1 - BYPASS;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);
  localparam state_t     BR_NEXT    = (FLUSH_CYC == 1) ? ST_RUN : ST_FLUSH;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_flush_cnt;
  logic [2:0]            w_flush_cnt_nxt;
  logic [DEPTH-1:0]      r_slot_v;
  logic [DEPTH-1:0][2:0] r_slot_rd;
  logic [15:0]           r_stall_cnt;
  logic                  w_match;
  logic                  w_hazard;
  logic                  w_issue;
  logic                  w_branch;
  logic                  w_nop;
  logic                  w_stall_pc;
  logic                  w_stall_ifid;
  logic                  w_flush;

  // Compare decode sources against the writers not yet covered by bypass.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i <= CMP_LAST; i++) begin
      w_match = w_match | (r_slot_v[i] &
                ((bus.id_rs_used & (bus.id_rs == r_slot_rd[i])) |
                 (bus.id_rt_used & (bus.id_rt == r_slot_rd[i]))));
    end
  end

  assign w_branch = bus.ex_branch_taken & (r_state != ST_HALTED);
  assign w_hazard = bus.id_valid & (r_state == ST_RUN) & ~bus.ex_branch_taken & w_match;
  assign w_issue  = bus.id_valid & (r_state == ST_RUN) & ~w_hazard & ~bus.ex_branch_taken;

  // Next-state and control outputs; a taken branch outranks everything but HALTED.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_nop           = 1'b0;
    w_stall_pc      = 1'b0;
    w_stall_ifid    = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_branch) begin
          w_flush         = 1'b1;
          w_nop           = 1'b1;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_state_nxt     = BR_NEXT;
        end else if (w_hazard) begin
          w_nop        = 1'b1;
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
        end else if (w_issue && bus.id_halt) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        w_nop   = 1'b1;
        if (w_branch) begin
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_state_nxt     = BR_NEXT;
        end else if (r_flush_cnt <= 3'd1) begin
          w_flush_cnt_nxt = 3'd0;
          w_state_nxt     = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end
      ST_DRAIN: begin
        if (w_branch) begin
          // An older branch resolving now cancels the halt.
          w_flush         = 1'b1;
          w_nop           = 1'b1;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_state_nxt     = BR_NEXT;
        end else begin
          w_nop        = 1'b1;
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          // Only bubbles enter while draining, so once the younger slots are
          // empty the scoreboard is empty on the next edge.
          if (r_slot_v[DEPTH-2:0] == {(DEPTH-1){1'b0}}) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_HALTED: begin
        w_nop        = 1'b1;
        w_stall_pc   = 1'b1;
        w_stall_ifid = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Scoreboard shift: a non-issuing cycle inserts a bubble at slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_v  <= {DEPTH{1'b0}};
      r_slot_rd <= {(DEPTH*3){1'b0}};
    end else begin
      r_slot_v  <= {r_slot_v[DEPTH-2:0], w_issue & bus.id_regwrt};
      r_slot_rd <= {r_slot_rd[DEPTH-2:0], bus.id_rd};
    end
  end

  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.nop_mech   = w_nop;
  assign bus.stall_pc   = w_stall_pc;
  assign bus.stall_ifid = w_stall_ifid;
  assign bus.flush_ifid = w_flush;
  assign bus.halted     = (r_state == ST_HALTED);
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: the driver computes expected outputs
// from a writer-history reference model and queues them; a negedge monitor
// pops and compares. Directed checks cover the named pipeline scenarios.
module tb_hazard_sched;
  localparam int DEPTH     = 3;
  localparam int BYPASS    = 1;
  localparam int FLUSH_CYC = 2;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALTED = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_sched_if bus();

  hazard_sched #(.DEPTH(DEPTH), .BYPASS(BYPASS), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        nop;
    logic        spc;
    logic        sif;
    logic        fl;
    logic        hlt;
    logic [15:0] cnt;
    logic [1:0]  st;
  } out_t;

  typedef struct {
    int cyc;
    int rd;
  } wr_t;

  out_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // reference model: list of issued writers tagged with their issue cycle
  wr_t m_hist[$];
  int  m_cyc = 0, m_mode = M_RUN, m_left = 0, m_stall = 0;
  bit  p_haz, p_iss, p_br, p_halt, p_rw;
  int  p_rd;

  function automatic bit reads_recent(int rs, bit rsu, int rt, bit rtu);
    foreach (m_hist[k]) begin
      int age = m_cyc - m_hist[k].cyc;
      if (age >= 1 && age <= DEPTH - BYPASS &&
          ((rsu && rs == m_hist[k].rd) || (rtu && rt == m_hist[k].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // true when some writer will still be inside the pipeline after this edge
  function automatic bit pending_next();
    foreach (m_hist[k]) begin
      int age = m_cyc - m_hist[k].cyc;
      if (age >= 1 && age + 1 <= DEPTH) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Drive one decode cycle and queue the expected response.
  task automatic apply(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit rw, bit halt, bit br);
    out_t e;
    bus.id_valid = v; bus.id_rs = 3'(rs); bus.id_rs_used = rsu;
    bus.id_rt = 3'(rt); bus.id_rt_used = rtu; bus.id_rd = 3'(rd);
    bus.id_regwrt = rw; bus.id_halt = halt; bus.ex_branch_taken = br;
    p_br   = br && (m_mode != M_HALTED);
    p_haz  = v && (m_mode == M_RUN) && !br && reads_recent(rs, rsu, rt, rtu);
    p_iss  = v && (m_mode == M_RUN) && !p_haz && !br;
    p_halt = halt; p_rw = rw; p_rd = rd;
    e = '0;
    e.cnt = 16'(m_stall);
    e.st  = 2'(m_mode);
    if (m_mode == M_HALTED) begin
      e.nop = 1'b1; e.spc = 1'b1; e.sif = 1'b1; e.hlt = 1'b1;
    end else if (p_br) begin
      e.fl = 1'b1; e.nop = 1'b1;
    end else if (m_mode == M_RUN && p_haz) begin
      e.nop = 1'b1; e.spc = 1'b1; e.sif = 1'b1;
    end else if (m_mode == M_FLUSH) begin
      e.fl = 1'b1; e.nop = 1'b1;
    end else if (m_mode == M_DRAIN) begin
      e.nop = 1'b1; e.spc = 1'b1; e.sif = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Advance the clock and the reference model by one cycle.
  task automatic tick();
    bit   pend;
    wr_t  w;
    @(posedge clk);
    pend = pending_next();
    if (p_iss && p_rw) begin
      w.cyc = m_cyc; w.rd = p_rd;
      m_hist.push_back(w);
    end
    if (p_haz && m_stall < 65535) m_stall++;
    if (m_mode == M_HALTED) begin
      m_mode = M_HALTED;
    end else if (p_br) begin
      m_left = FLUSH_CYC - 1;
      m_mode = (m_left == 0) ? M_RUN : M_FLUSH;
    end else if (m_mode == M_RUN) begin
      if (p_iss && p_halt) m_mode = M_DRAIN;
    end else if (m_mode == M_FLUSH) begin
      m_left--;
      if (m_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_DRAIN) begin
      if (!pend) m_mode = M_HALTED;
    end
    m_cyc++;
    while (m_hist.size() > 0 && (m_cyc - m_hist[0].cyc) > DEPTH) void'(m_hist.pop_front());
    #1;
  endtask

  task automatic step(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit rw, bit halt, bit br);
    apply(v, rs, rsu, rt, rtu, rd, rw, halt, br);
    tick();
  endtask

  task automatic rnd_step(int halt_pct, int br_pct);
    step($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
         $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
         $urandom_range(0, 1) == 1, $urandom_range(0, 99) < halt_pct,
         $urandom_range(0, 99) < br_pct);
  endtask

  // Assert reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(int ncyc);
    out_t z;
    z = '0;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs = 3'd0; bus.id_rs_used = 1'b0;
    bus.id_rt = 3'd0; bus.id_rt_used = 1'b0; bus.id_rd = 3'd0;
    bus.id_regwrt = 1'b0; bus.id_halt = 1'b0; bus.ex_branch_taken = 1'b0;
    m_hist.delete();
    m_mode = M_RUN; m_left = 0; m_stall = 0;
    p_haz = 1'b0; p_iss = 1'b0; p_br = 1'b0; p_halt = 1'b0; p_rw = 1'b0; p_rd = 0;
    for (int i = 0; i < ncyc; i++) begin
      exp_q.push_back(z);
      if (i == 0) begin
        #3;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_ctl", int'({bus.nop_mech, bus.stall_pc, bus.halted}), 0);
        chk("async_rst_cnt", int'(bus.stall_cnt), 0);
      end
      @(posedge clk);
      m_cyc++;
      #1;
    end
    rst = 1'b0;
  endtask

  // Scoreboard monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = {bus.nop_mech, bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.halted,
           bus.stall_cnt, bus.state};
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL outputs t=%0t got nop/spc/sif/fl/hlt=%b%b%b%b%b cnt=%0d st=%0d expected %b%b%b%b%b cnt=%0d st=%0d",
                 $time, a.nop, a.spc, a.sif, a.fl, a.hlt, a.cnt, a.st,
                 e.nop, e.spc, e.sif, e.fl, e.hlt, e.cnt, e.st);
      end
    end
  end

  initial begin
    bus.id_valid = 1'b0; bus.id_rs = 3'd0; bus.id_rs_used = 1'b0;
    bus.id_rt = 3'd0; bus.id_rt_used = 1'b0; bus.id_rd = 3'd0;
    bus.id_regwrt = 1'b0; bus.id_halt = 1'b0; bus.ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // randomized rounds, each ending in a mid-stream reset
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 200; c++) rnd_step(1, 6);
      do_reset($urandom_range(1, 3));
    end

    // RAW on rs against the previous writer: two stall cycles, then issue
    step(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("raw_nop", int'(bus.nop_mech), (c < 2) ? 1 : 0);
      chk("raw_stall_pc", int'(bus.stall_pc), (c < 2) ? 1 : 0);
      if (c == 2) chk("raw_stall_cnt", int'(bus.stall_cnt), 2);
      tick();
    end

    // writer three cycles back is covered by bypass
    step(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    #3; chk("bypass_no_stall", int'(bus.nop_mech), 0);
    tick();
    // matching rt that is not actually read
    step(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 0, 1'b0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #3; chk("rt_unused_no_stall", int'(bus.nop_mech), 0);
    tick();

    // branch with a coincident hazard: flush twice, count unchanged
    apply(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    #3; chk("br_flush0", int'(bus.flush_ifid), 1); chk("br_state0", int'(bus.state), 0);
    chk("br_stall_pc0", int'(bus.stall_pc), 0);
    tick();
    apply(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #3; chk("br_flush1", int'(bus.flush_ifid), 1); chk("br_state1", int'(bus.state), 1);
    tick();
    apply(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #3; chk("br_flush2", int'(bus.flush_ifid), 0); chk("br_state2", int'(bus.state), 0);
    chk("br_stall_cnt", int'(bus.stall_cnt), 2);
    tick();

    // HALT with two writers in flight, then a long halted hold
    step(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("drain_state", int'(bus.state), (c < 2) ? 2 : 3);
      chk("drain_stall_pc", int'(bus.stall_pc), 1);
      tick();
    end
    for (int c = 0; c < 100; c++) begin
      apply($urandom_range(0, 1) == 1, $urandom_range(0, 7), 1'b1, $urandom_range(0, 7), 1'b1,
            0, 1'b1, 1'b0, $urandom_range(0, 3) == 0);
      #3;
      chk("halted_flag", int'(bus.halted), 1);
      chk("halted_state", int'(bus.state), 3);
      chk("halted_stall_pc", int'(bus.stall_pc), 1);
      tick();
    end
    do_reset(1);

    // branch arriving while draining cancels the halt
    step(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    #3; chk("drain_br_state", int'(bus.state), 2); chk("drain_br_flush", int'(bus.flush_ifid), 1);
    tick();
    apply(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #3; chk("cancel_state", int'(bus.state), 1); chk("cancel_halted", int'(bus.halted), 0);
    tick();
    apply(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
    #3; chk("resume_state", int'(bus.state), 0); chk("resume_nop", int'(bus.nop_mech), 0);
    tick();
    for (int c = 0; c < 200; c++) rnd_step(2, 8);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
